el_rx_bridge: RTL and testbench

- Downstream consumer of el_fib. Takes the dual-rail word from el_fib and its 2-phase toggle handshake, and moves each word into the synchronous clk domain.
- Synchronises the request toggle, lets the data settle, decodes and validates the dual-rail code, and buffers decoded words in a small FIFO with a valid/ready output.
- Returns the acknowledge toggle to el_fib. Replaces the per-bit el_sync array on the synchronous side of the async/sync boundary.

---
 rtl/el_rx_bridge_pkg.sv | 24 ++
 rtl/el_rx_fifo.sv | 68 ++++++
 rtl/el_rx_bridge.sv | 133 +++++++++++++
 tb/tb_el_rx_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/el_rx_bridge_pkg.sv
// Shared definitions for the el_rx_bridge: dual-rail codes, FSM states and code validation.
package el_rx_bridge_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ZERO = 2'b01;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } rx_state_e;

   function automatic logic dr_legal(input logic [1:0] code);
      logic ok;
      case (code)
         DR_ZERO, DR_ONE: ok = 1'b1;
         DR_NULL, DR_ILL: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/el_rx_fifo.sv
// Synchronous show-ahead FIFO; the head word is held in its own register so it survives emptying.
module el_rx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count;
   logic [AW-1:0]    rd_next_idx;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign empty_o     = (wr_ptr_q == rd_ptr_q);
   assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count       = wr_ptr_q - rd_ptr_q;
   assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
   assign do_pop      = pop_i && !empty_o;
   assign do_push     = push_i && (!full_o || do_pop);
   assign head_o      = head_q;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (count > PTR_ONE) head_d = mem_q[rd_next_idx];
         else if (do_push)    head_d = push_data_i;
      end else if (do_push && empty_o) begin
         head_d = push_data_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

   // NOTE: storage is not reset; a slot is only ever read after it has been written, and head_q supplies the reset value.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/el_rx_bridge.sv
// Receives dual-rail words over a 2-phase toggle handshake and delivers them decoded on a valid/ready FIFO.
module el_rx_bridge
   import el_rx_bridge_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RAIL_NUM   = 2,
   parameter int SETTLE_CYC = 2,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH*RAIL_NUM-1:0] in_data,
   input  logic                      in_req,
   output logic                      in_ack,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      err
);

   localparam int          CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

   generate
      if (RAIL_NUM != 2) begin : g_bad_rail
         $error("el_rx_bridge: only RAIL_NUM=2 is supported");
      end
      if (SETTLE_CYC < 1) begin : g_bad_settle
         $error("el_rx_bridge: SETTLE_CYC must be at least 1");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("el_rx_bridge: DEPTH must be a power of two, at least 2");
      end
   endgenerate

   logic             req_meta_q, req_s_q;
   rx_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] dec_word;
   logic             dec_legal;
   logic             pending, fifo_full, fifo_empty, fifo_pop, wr_allowed, push;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_meta_q <= 1'b0;
         req_s_q    <= 1'b0;
      end else begin
         req_meta_q <= in_req;
         req_s_q    <= req_meta_q;
      end
   end

   always_comb begin
      dec_word  = '0;
      dec_legal = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         dec_word[i] = in_data[2*i+1];
         dec_legal   = dec_legal & dr_legal(in_data[2*i +: 2]);
      end
   end

   assign pending    = (req_s_q != ack_q);
   assign fifo_pop   = out_ready && !fifo_empty;
   assign wr_allowed = !fifo_full || fifo_pop;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               cnt_d   = SETTLE_LOAD;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_CAPTURE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_CAPTURE: begin
            // A full FIFO holds the word here and withholds the ack, back-pressuring the producer.
            if (!dec_legal) begin
               err_d   = 1'b1;
               ack_d   = ~ack_q;
               state_d = ST_IDLE;
            end else if (wr_allowed) begin
               push    = 1'b1;
               ack_d   = ~ack_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   el_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (dec_word),
      .full_o      (fifo_full),
      .pop_i       (fifo_pop),
      .empty_o     (fifo_empty),
      .head_o      (out_data)
   );

   assign out_valid = !fifo_empty;
   assign in_ack    = ack_q;
   assign err       = err_q;

endmodule

// File: tb/tb_el_rx_bridge.sv
// Randomised bench for el_rx_bridge: a toggle-handshake producer, a random-ready consumer and a word-queue model.
module tb_el_rx_bridge;

   localparam int WIDTH      = 32;
   localparam int RAIL_NUM   = 2;
   localparam int SETTLE_CYC = 2;
   localparam int DEPTH      = 4;
   // Posedges from the request toggle to the visible ack, counting the sampling edge itself.
   localparam int LAT        = SETTLE_CYC + 4;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [WIDTH*RAIL_NUM-1:0] in_data = '0;
   logic                      in_req = 1'b0;
   logic                      in_ack;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
   logic                      err;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic        exp_err  = 1'b0;
   int          rdy_mode = 0;
   logic [31:0] last_pop = '0;

   always #5 clk = ~clk;

   el_rx_bridge #(
      .WIDTH      (WIDTH),
      .RAIL_NUM   (RAIL_NUM),
      .SETTLE_CYC (SETTLE_CYC),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_req    (in_req),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] enc(input logic [31:0] w, input int bad_bit, input logic [1:0] bad_code);
      logic [63:0] d;
      for (int i = 0; i < 32; i++) d[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
      if (bad_bit >= 0) d[2*bad_bit +: 2] = bad_code;
      return d;
   endfunction

   // Consumer: picks out_ready each cycle and checks every accepted word against the model queue.
   always begin
      @(negedge clk);
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_without_word", {63'd0, out_valid}, 64'd0);
         end else begin
            last_pop = exp_q.pop_front();
            check("pop_data", {32'd0, out_data}, {32'd0, last_pop});
         end
      end
   end

   task automatic launch(input logic [31:0] w, input int bad_bit, input logic [1:0] bad_code);
      @(negedge clk);
      in_data = enc(w, bad_bit, bad_code);
      in_req  = ~in_req;
      if (bad_bit < 0) exp_q.push_back(w);
      else             exp_err = 1'b1;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (in_ack !== in_req && n < 200) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("ack_returned", {63'd0, in_ack}, {63'd0, in_req});
   endtask

   task automatic send(input logic [31:0] w, input int bad_bit, input logic [1:0] bad_code);
      int n;
      launch(w, bad_bit, bad_code);
      wait_ack(n);
   endtask

   task automatic drain();
      int n;
      @(posedge clk);
      rdy_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         #2;
         n++;
      end
      @(negedge clk);
      #2;
      check("drain_model_empty", exp_q.size(), 64'd0);
      check("drain_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      rdy_mode = 0;
   endtask

   task automatic check_withheld(input string tag, input int cycles);
      logic want;
      repeat (cycles) @(negedge clk);
      want = ~in_req;
      check(tag, {63'd0, in_ack}, {63'd0, want});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      in_req  = 1'b0;
      exp_q.delete();
      exp_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int lat;
      logic [31:0] fa, fb, fn;

      // Reset held with random producer activity: outputs stay at reset values.
      repeat (6) begin
         @(negedge clk);
         in_req  = 1'($urandom_range(0, 1));
         in_data = {$urandom, $urandom};
         #1;
         check("rst_in_ack", {63'd0, in_ack}, 64'd0);
         check("rst_out_valid", {63'd0, out_valid}, 64'd0);
         check("rst_out_data", {32'd0, out_data}, 64'd0);
         check("rst_err", {63'd0, err}, 64'd0);
      end
      @(negedge clk);
      in_req  = 1'b0;
      in_data = enc(32'd0, -1, 2'b00);
      rst     = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_in_ack", {63'd0, in_ack}, 64'd0);
      check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("post_rst_err", {63'd0, err}, 64'd0);

      // Single word: latency, show-ahead head, hold after emptying.
      launch(32'h0000_0005, -1, 2'b00);
      wait_ack(lat);
      check("t2_latency", lat, LAT);
      check("t2_out_valid", {63'd0, out_valid}, 64'd1);
      check("t2_out_data", {32'd0, out_data}, 64'h5);
      drain();
      check("t2_hold_data", {32'd0, out_data}, 64'h5);

      // Backpressure: four words fill the FIFO, the fifth waits for the first pop.
      send(32'd1, -1, 2'b00);
      send(32'd1, -1, 2'b00);
      send(32'd2, -1, 2'b00);
      send(32'd3, -1, 2'b00);
      launch(32'd5, -1, 2'b00);
      check_withheld("t3_fifth_withheld", 30);
      @(posedge clk);
      rdy_mode = 1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      check("t3_ack_on_first_pop", {63'd0, in_ack}, {63'd0, in_req});
      drain();

      // Illegal code is dropped without occupying a slot; err is sticky.
      send(32'd10, -1, 2'b00);
      send(32'd11, -1, 2'b00);
      send(32'd12, -1, 2'b00);
      send(32'd13, 3, 2'b11);
      check("t4_err_set", {63'd0, err}, {63'd0, exp_err});
      send(32'd14, -1, 2'b00);
      launch(32'd15, -1, 2'b00);
      check_withheld("t4_full_after_illegal", 20);
      drain();
      check("t4_err_sticky", {63'd0, err}, 64'd1);

      // Null code behaves like an illegal one; reset clears err.
      send(32'h20, 0, 2'b00);
      check("t5_err", {63'd0, err}, 64'd1);
      check("t5_no_word", {63'd0, out_valid}, 64'd0);
      do_reset();
      @(negedge clk);
      check("t5_err_cleared", {63'd0, err}, {63'd0, exp_err});

      // Reset during SETTLE aborts the transfer.
      launch(32'h77, -1, 2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      in_req = 1'b0;
      exp_q.delete();
      #1;
      check("t6_in_ack", {63'd0, in_ack}, 64'd0);
      check("t6_out_valid", {63'd0, out_valid}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send(32'hCAFE_0001, -1, 2'b00);
      check("t6_fresh_valid", {63'd0, out_valid}, 64'd1);
      drain();

      // Fibonacci stream with a randomly stalling consumer.
      rdy_mode = 2;
      fa = 32'd1;
      fb = 32'd1;
      for (int k = 0; k < 20; k++) begin
         send(fa, -1, 2'b00);
         fn = fa + fb;
         fa = fb;
         fb = fn;
      end
      drain();
      check("t7_last_word", {32'd0, last_pop}, 64'd6765);
      check("t7_err", {63'd0, err}, 64'd0);

      // Random words with occasional null/illegal bits.
      rdy_mode = 2;
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 5) == 0)
            send($urandom, int'($urandom_range(0, 31)), $urandom_range(0, 1) == 0 ? 2'b00 : 2'b11);
         else
            send($urandom, -1, 2'b00);
      end
      drain();
      check("t8_err", {63'd0, err}, {63'd0, exp_err});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
